// File: rtl/echo_pkg.sv
// Shared types and default widths for the echo detector slice.
package echo_pkg;

    localparam int unsigned ECHO_DATA_WIDTH = 16;
    localparam int unsigned ECHO_TIME_WIDTH = 24;

    typedef enum logic [2:0] {
        IDLE,
        BLANK,
        ARMED,
        DETECTED,
        EXPIRED
    } echo_state_t;

endpackage

// File: rtl/moving_average.sv
// Boxcar average over the last 2^AVG_LOG2 rectified samples; flush empties the window.
module moving_average
    import echo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = ECHO_DATA_WIDTH,
    parameter int unsigned AVG_LOG2   = 3
) (
    input  logic                           clk_100mhz,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [DATA_WIDTH-1:0]          rect,
    input  logic                           rect_valid,
    output logic [DATA_WIDTH+AVG_LOG2-1:0] sum,
    output logic [DATA_WIDTH-1:0]          envelope,
    output logic                           envelope_valid
);

    localparam int unsigned DEPTH = 2 ** AVG_LOG2;
    localparam int unsigned SUM_W = DATA_WIDTH + AVG_LOG2;

    // Newest sample sits in the low slot, oldest in the high slot.
    logic [DEPTH*DATA_WIDTH-1:0] window;
    logic [DATA_WIDTH-1:0]       oldest;

    assign oldest   = window[DEPTH*DATA_WIDTH-1 -: DATA_WIDTH];
    assign envelope = sum[AVG_LOG2 +: DATA_WIDTH];

    always_ff @(posedge clk_100mhz) begin
        if (rst || flush) begin
            window         <= '0;
            sum            <= '0;
            envelope_valid <= 1'b0;
        end else begin
            envelope_valid <= rect_valid;
            if (rect_valid) begin
                window <= {window[(DEPTH-1)*DATA_WIDTH-1:0], rect};
                sum    <= sum + SUM_W'(rect) - SUM_W'(oldest);
            end
        end
    end

endmodule

// File: rtl/echo_detector.sv
// Envelope-based echo detector: blanking, hysteresis threshold with minimum run,
// one time-stamped echo or a timeout per burst period.
module echo_detector
    import echo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = ECHO_DATA_WIDTH,
    parameter int unsigned MIDSCALE      = 32768,
    parameter int unsigned AVG_LOG2      = 3,
    parameter int unsigned THRESHOLD     = 2000,
    parameter int unsigned HYST          = 500,
    parameter int unsigned MIN_HITS      = 4,
    parameter int unsigned TIME_WIDTH    = ECHO_TIME_WIDTH,
    parameter int unsigned BLANK_CYCLES  = 600000,
    parameter int unsigned LISTEN_CYCLES = 16000000
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  burst_start_in,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid_in,
    output logic [DATA_WIDTH-1:0] envelope_out,
    output logic                  envelope_valid_out,
    output logic                  echo_detected_out,
    output logic                  echo_valid_out,
    output logic [TIME_WIDTH-1:0] echo_time_out,
    output logic [DATA_WIDTH-1:0] peak_out,
    output logic                  timeout_out
);

    localparam int unsigned SUM_W     = DATA_WIDTH + AVG_LOG2;
    localparam int unsigned HIT_W     = $clog2(MIN_HITS + 1);
    localparam int unsigned LOW_LEVEL = (THRESHOLD > HYST) ? THRESHOLD - HYST : 0;

    localparam logic [DATA_WIDTH:0]   MID_X    = (DATA_WIDTH+1)'(MIDSCALE);
    localparam logic [DATA_WIDTH:0]   RECT_MAX = (DATA_WIDTH+1)'((2 ** (DATA_WIDTH-1)) - 1);
    // Thresholds scaled to the window sum: sum >= T*2^k  <=>  (sum >> k) >= T.
    localparam logic [SUM_W-1:0]      SUM_HIT  = SUM_W'(THRESHOLD << AVG_LOG2);
    localparam logic [SUM_W-1:0]      SUM_LOW  = SUM_W'(LOW_LEVEL << AVG_LOG2);
    localparam logic [HIT_W-1:0]      LAST_HIT = HIT_W'(MIN_HITS - 1);
    localparam logic [TIME_WIDTH-1:0] BLANK_T  = TIME_WIDTH'(BLANK_CYCLES);
    localparam logic [TIME_WIDTH-1:0] LISTEN_T = TIME_WIDTH'(LISTEN_CYCLES);

    echo_state_t            state_q, state_d;
    logic [TIME_WIDTH-1:0]  timer_q;
    logic [DATA_WIDTH:0]    diff;
    logic [DATA_WIDTH-1:0]  rect_d, rect_q;
    logic                   rect_valid_q;
    logic [TIME_WIDTH-1:0]  ts1_q, ts2_q, run_ts_q;
    logic [SUM_W-1:0]       win_sum;
    logic [HIT_W-1:0]       hit_cnt_q;
    logic                   accept, env_hit, env_low, detect_now;

    always_comb begin
        if ({1'b0, sample_in} >= MID_X) diff = {1'b0, sample_in} - MID_X;
        else                            diff = MID_X - {1'b0, sample_in};
        rect_d = (diff > RECT_MAX) ? RECT_MAX[DATA_WIDTH-1:0] : diff[DATA_WIDTH-1:0];
    end

    assign accept  = sample_valid_in && !burst_start_in && (state_q != IDLE);
    assign env_hit = win_sum >= SUM_HIT;
    assign env_low = win_sum < SUM_LOW;

    always_ff @(posedge clk_in) begin
        if (rst_in || burst_start_in) begin
            timer_q      <= '0;
            rect_valid_q <= 1'b0;
        end else begin
            if (timer_q != '1) timer_q <= timer_q + TIME_WIDTH'(1);
            rect_valid_q <= accept;
        end
        if (accept) begin
            rect_q <= rect_d;
            ts1_q  <= timer_q;
        end
        if (rect_valid_q) ts2_q <= ts1_q;
    end

    moving_average #(
        .DATA_WIDTH (DATA_WIDTH),
        .AVG_LOG2   (AVG_LOG2)
    ) u_avg (
        .clk_100mhz     (clk_in),
        .rst            (rst_in),
        .flush          (burst_start_in),
        .rect           (rect_q),
        .rect_valid     (rect_valid_q),
        .sum            (win_sum),
        .envelope       (envelope_out),
        .envelope_valid (envelope_valid_out)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (burst_start_in) begin
            state_d = BLANK;
        end else begin
            case (state_q)
                BLANK:   if (timer_q >= BLANK_T) state_d = ARMED;
                ARMED:   if (detect_now) state_d = DETECTED;
                         else if (timer_q >= LISTEN_T) state_d = EXPIRED;
                default: state_d = state_q;
            endcase
        end
    end

    // Detection takes precedence over a timeout landing in the same cycle.
    always_comb begin
        detect_now  = 1'b0;
        timeout_out = 1'b0;
        if (!rst_in && !burst_start_in && state_q == ARMED) begin
            detect_now  = envelope_valid_out && env_hit && (hit_cnt_q == LAST_HIT);
            timeout_out = !detect_now && (timer_q >= LISTEN_T);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in || burst_start_in) begin
            hit_cnt_q         <= '0;
            run_ts_q          <= '0;
            echo_time_out     <= '0;
            echo_detected_out <= 1'b0;
            echo_valid_out    <= 1'b0;
            peak_out          <= '0;
        end else begin
            echo_valid_out <= detect_now;
            if (state_q == ARMED && envelope_valid_out) begin
                if (env_hit) begin
                    hit_cnt_q <= hit_cnt_q + HIT_W'(1);
                    if (hit_cnt_q == '0) run_ts_q <= ts2_q;
                end else if (env_low) begin
                    hit_cnt_q <= '0;
                end
            end
            if (detect_now) begin
                echo_detected_out <= 1'b1;
                echo_time_out     <= (hit_cnt_q == '0) ? ts2_q : run_ts_q;
            end
            if (envelope_valid_out && (state_q == ARMED || state_q == DETECTED)
                && envelope_out > peak_out)
                peak_out <= envelope_out;
        end
    end

endmodule

// File: tb/tb_echo_detector.sv
// Randomized and directed scoreboard bench for echo_detector with a period-level reference model.
module tb_echo_detector;

    localparam int DW      = 16;
    localparam int MID     = 32768;
    localparam int AVG     = 3;
    localparam int TH      = 2000;
    localparam int HYST    = 500;
    localparam int LOW     = TH - HYST;
    localparam int MINH    = 4;
    localparam int TW      = 24;
    localparam int BLANK   = 200;
    localparam int LISTEN  = 2000;
    localparam int RMAX    = 32767;
    localparam int TMAX    = (1 << TW) - 1;

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic          burst_start_in;
    logic [DW-1:0] sample_in;
    logic          sample_valid_in;
    logic [DW-1:0] envelope_out;
    logic          envelope_valid_out;
    logic          echo_detected_out;
    logic          echo_valid_out;
    logic [TW-1:0] echo_time_out;
    logic [DW-1:0] peak_out;
    logic          timeout_out;

    always #5 clk_in = ~clk_in;

    echo_detector #(
        .DATA_WIDTH    (DW),
        .MIDSCALE      (MID),
        .AVG_LOG2      (AVG),
        .THRESHOLD     (TH),
        .HYST          (HYST),
        .MIN_HITS      (MINH),
        .TIME_WIDTH    (TW),
        .BLANK_CYCLES  (BLANK),
        .LISTEN_CYCLES (LISTEN)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .burst_start_in     (burst_start_in),
        .sample_in          (sample_in),
        .sample_valid_in    (sample_valid_in),
        .envelope_out       (envelope_out),
        .envelope_valid_out (envelope_valid_out),
        .echo_detected_out  (echo_detected_out),
        .echo_valid_out     (echo_valid_out),
        .echo_time_out      (echo_time_out),
        .peak_out           (peak_out),
        .timeout_out        (timeout_out)
    );

    typedef struct { int cyc; int val; } exp_t;
    typedef struct { int cyc; int env; int ts; } eval_t;

    exp_t  env_q[$];
    exp_t  echo_q[$];
    exp_t  to_q[$];
    eval_t pend_q[$];
    int    win_q[$];

    int cyc     = 0;
    int checks  = 0;
    int passed  = 0;
    bit mon_en  = 0;

    // Reference model state: one burst period at a time.
    bit started = 0;
    bit det     = 0;
    int hits    = 0;
    int run_ts  = 0;
    int m_timer = 0;
    int det_vis = 0, det_nxt = 0;
    int peak_vis = 0, peak_nxt = 0;
    int et_vis = 0, et_nxt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    // Envelope of a sample = mean of the last 8 rectified samples since the burst (missing ones are 0).
    // It is judged 2 clocks after issue, with the period timer value of that clock.
    task automatic model_step(input bit b, input bit v, input int s);
        eval_t ev;
        int r, sum, env_v;
        det_vis  = det_nxt;
        peak_vis = peak_nxt;
        et_vis   = et_nxt;
        while (pend_q.size() > 0 && pend_q[0].cyc == cyc) begin
            ev = pend_q.pop_front();
            if (!b) begin
                if (!det && m_timer > BLANK && m_timer <= LISTEN) begin
                    if (ev.env >= TH) begin
                        if (hits == 0) run_ts = ev.ts;
                        hits++;
                        if (hits == MINH) begin
                            det     = 1;
                            det_nxt = 1;
                            et_nxt  = run_ts;
                            echo_q.push_back('{cyc + 1, run_ts});
                        end
                    end else if (ev.env < LOW) begin
                        hits = 0;
                    end
                end
                if (m_timer > BLANK && (det || m_timer <= LISTEN) && ev.env > peak_nxt)
                    peak_nxt = ev.env;
            end
        end
        if (started && !b && !det && m_timer == LISTEN)
            to_q.push_back('{cyc, 0});
        if (b) begin
            started = 1;
            win_q.delete();
            pend_q.delete();
            while (env_q.size() > 0 && env_q[env_q.size()-1].cyc > cyc)
                env_q.delete(env_q.size() - 1);
            hits = 0; det = 0; det_nxt = 0; peak_nxt = 0; et_nxt = 0;
            m_timer = 0;
        end else begin
            if (v && started) begin
                r = s - MID;
                if (r < 0) r = -r;
                if (r > RMAX) r = RMAX;
                win_q.push_back(r);
                if (win_q.size() > (1 << AVG)) win_q.delete(0);
                sum = 0;
                foreach (win_q[i]) sum += win_q[i];
                env_v = sum >> AVG;
                pend_q.push_back('{cyc + 2, env_v, m_timer});
                env_q.push_back('{cyc + 2, env_v});
            end
            if (m_timer < TMAX) m_timer++;
        end
    endtask

    task automatic step(input bit b, input bit v, input int s);
        @(posedge clk_in);
        #1;
        rst_in          = 1'b0;
        burst_start_in  = b;
        sample_valid_in = v;
        sample_in       = v ? DW'(s) : DW'($urandom);
        cyc++;
        model_step(b, v, s);
        mon_en = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    task automatic feed(input int n, input int s);
        for (int i = 0; i < n; i++) step(0, 1, s);
    endtask

    task automatic feed_rects(input int r[$]);
        foreach (r[i]) step(0, 1, MID + r[i]);
    endtask

    exp_t mx;
    bit   mev;

    always @(negedge clk_in) begin
        if (mon_en) begin
            mev = env_q.size() > 0 && env_q[0].cyc == cyc;
            check("envelope_valid", envelope_valid_out, mev);
            if (mev) begin
                mx = env_q.pop_front();
                check("envelope", envelope_out, mx.val);
            end
            mev = echo_q.size() > 0 && echo_q[0].cyc == cyc;
            check("echo_valid", echo_valid_out, mev);
            if (mev) begin
                mx = echo_q.pop_front();
                check("echo_time_at_pulse", echo_time_out, mx.val);
            end
            mev = to_q.size() > 0 && to_q[0].cyc == cyc;
            check("timeout", timeout_out, mev);
            if (mev) void'(to_q.pop_front());
            check("echo_detected", echo_detected_out, det_vis);
            check("peak", peak_out, peak_vis);
            check("echo_time", echo_time_out, et_vis);
        end
    end

    int len, amp, s;
    bit v;

    initial begin
        rst_in = 1'b1; burst_start_in = 1'b0; sample_valid_in = 1'b0; sample_in = DW'(MID);
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_envelope", envelope_out, 0);
        check("rst_envelope_valid", envelope_valid_out, 0);
        check("rst_echo_detected", echo_detected_out, 0);
        check("rst_echo_valid", echo_valid_out, 0);
        check("rst_echo_time", echo_time_out, 0);
        check("rst_peak", peak_out, 0);
        check("rst_timeout", timeout_out, 0);

        // Samples before any burst are ignored in IDLE.
        feed(12, 40000);
        // Midscale input through a whole period: zero envelope, timeout at LISTEN.
        step(1, 0, 0);
        feed(LISTEN + 20, MID);
        // 40000 during blanking: envelope climbs to 7232 without detection.
        step(1, 0, 0);
        idle(20);
        feed(40, 40000);
        idle(20);
        // Same samples after blanking: echo on the 6th, timed at the 3rd.
        step(1, 0, 0);
        idle(BLANK + 5);
        feed(10, 40000);
        idle(20);
        // Envelope 2500,2500,1800,2500,2500 after blanking -> detection.
        step(1, 0, 0);
        idle(BLANK - 30);
        feed_rects('{2400, 2400, 5600, 0, 2400, 2400, 2400, 2400});
        idle(40);
        feed_rects('{2400, 2400, 0, 5600, 2400});
        idle(20);
        // Envelope 2500,2500,1200,2500,2500 -> run broken, then timeout.
        step(1, 0, 0);
        idle(BLANK - 30);
        feed_rects('{1600, 1600, 10400, 0, 1600, 1600, 1600, 1600});
        idle(40);
        feed_rects('{1600, 1600, 0, 10400, 1600});
        idle(LISTEN);
        // Burst mid-run with three hits, coinciding sample dropped, then negative input.
        step(1, 0, 0);
        idle(BLANK + 5);
        feed(5, 40000);
        idle(2);
        step(1, 1, 40000);
        idle(BLANK + 5);
        feed(12, 20000);
        idle(10);
        // Random periods with random early bursts, gaps and saturating samples.
        for (int p = 0; p < 6; p++) begin
            amp = (p % 3 == 0) ? 1200 : ((p % 3 == 1) ? 2800 : 7000);
            len = $urandom_range(300, LISTEN + 150);
            step(1, 1'($urandom_range(0, 1)), 40000);
            for (int k = 0; k < len; k++) begin
                v = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 49) == 0) s = ($urandom_range(0, 1) != 0) ? 0 : 65535;
                else s = MID + $urandom_range(0, 2 * amp) - amp;
                step(0, v, s);
            end
        end
        idle(10);
        @(posedge clk_in);
        #1;
        check("env_queue_drained", env_q.size(), 0);
        check("echo_queue_drained", echo_q.size(), 0);
        check("timeout_queue_drained", to_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
